// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One full-adder slice is stepped over two WIDTH-bit operands, LSB first,
// with a start/busy/done handshake toward the requester.
// Optional macro SERIAL_ADDER_SUB_EN adds port i_sub: when it is set, the
// slice is fed ~b and the carry flop starts at 1, so the block subtracts.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sum_bit_c;
    logic             carry_next_c;
    logic             b_load_c;
    logic             carry_init_c;
    logic [WIDTH-1:0] b_in_c;

    // Operand B and carry seed as loaded on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_c     = i_sub;
`else
    assign b_load_c     = 1'b0;
`endif
    assign carry_init_c = b_load_c;
    assign b_in_c       = b_load_c ? ~i_b : i_b;

    // Single full-adder slice: two half adders plus an OR.
    always_comb begin
        sum_bit_c    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_start) state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST_BIT) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry flop and bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == ST_IDLE && i_start) begin
            a_sr  <= i_a;
            b_sr  <= b_in_c;
            carry <= carry_init_c;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            carry <= carry_next_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result registers: sum bits enter at the MSB; carry captured on the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else if (state == ST_RUN) begin
            o_sum <= {sum_bit_c, o_sum[WIDTH-1:1]};
            if (cnt == LAST_BIT) begin
                o_carry <= carry_next_c;
            end
        end
    end

    // Handshake flags, registered from the next state so they track it exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_busy <= (state_next == ST_RUN);
            o_done <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed plus randomized checks of serial_adder_ctrl
// (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int tests = 0;
    int fails = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .i_sub   (sub),
`endif
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    // Issue one op from a negedge; returns at the negedge where o_done is seen.
    // exp_acc = number of posedges until the start is accepted.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input bit hold, input int exp_acc, input string tag);
        logic [W:0] exp;
        int acc;
        int n;
        int busy_n;
        int overlap;
        exp     = model(x, y, s);
        a       = x;
        b       = y;
        sub     = s;
        start   = 1'b1;
        acc     = 0;
        n       = 0;
        busy_n  = 0;
        overlap = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            acc++;
            if (busy) break;
        end
        chk({tag, "_accept"}, 32'(acc), 32'(exp_acc));
        if (!hold) start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (busy && done) overlap++;
            if (hold) a = W'($urandom);
            if (done) break;
            if (busy) busy_n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        chk({tag, "_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, "_carry"}, 32'(carry), 32'(exp[W]));
    endtask

    initial begin
        int bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero operands
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 1, "t1");
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // 2: FF + 01, result held while idle
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, "t2");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (sum !== 8'h00 || carry !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("t2_hold", 32'(bad), 32'd0);

        // 3: start held through RUN/DONE while i_a changes
        run_op(8'hA5, 8'h5A, 1'b0, 1'b1, 1, "t3");
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t3_idle_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_no_second_op", 32'(busy), 32'd0);
        chk("t3_sum_held", 32'(sum), 32'hFF);

        // 4: reset pulse mid-operation
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        chk("t4_rst_sum", 32'(sum), 32'd0);
        chk("t4_rst_carry", 32'(carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("t4_no_done", 32'(bad), 32'd0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1, "t4_after");

        // 5: back-to-back, second start raised in the DONE cycle
        @(negedge clk);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1, "t5a");
        run_op(8'hF0, 8'h10, 1'b0, 1'b0, 2, "t5b");
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction
        run_op(8'h05, 8'h07, 1'b1, 1'b0, 1, "t6a");
        @(negedge clk);
        run_op(8'h07, 8'h05, 1'b1, 1'b0, 1, "t6b");
        @(negedge clk);
`endif

        // Randomized operands against the model
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1, "rnd");
`else
            run_op(ra, rb, 1'b0, 1'b0, 1, "rnd");
`endif
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
